// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT PLL sequencing path: controller state codes,
// phase-detector result codes and the default frequency/gain values.
package swipt_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_ACQUIRE = 3'd2;
    localparam logic [2:0] ST_TRACK   = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_LOAD    = ST_LOAD,
        S_ACQUIRE = ST_ACQUIRE,
        S_TRACK   = ST_TRACK,
        S_HOLD    = ST_HOLD
    } state_t;

    localparam logic [1:0] ERR_ALIGNED = 2'b00;
    localparam logic [1:0] ERR_EARLY   = 2'b01;
    localparam logic [1:0] ERR_LATE    = 2'b10;
    localparam logic [1:0] ERR_INVALID = 2'b11;

    localparam logic [31:0] F_DEFAULT_VAL = 32'h9C40;
    localparam logic [4:0]  LG_ACQ_VAL    = 5'd12;
    localparam logic [4:0]  LG_TRACK_VAL  = 5'd16;

endpackage

// File: rtl/freq_clamp.sv
// Combinational unsigned clamp of the PLL frequency word into [F_MIN, F_MAX],
// flagging any sample that had to be limited.
module freq_clamp #(
    parameter logic [31:0] F_MIN = 32'h8000,
    parameter logic [31:0] F_MAX = 32'hC000
) (
    input  logic [31:0] word_in,
    output logic [31:0] word_out,
    output logic        clamped
);

    always_comb begin
        word_out = word_in;
        clamped  = 1'b0;
        if (word_in < F_MIN) begin
            word_out = F_MIN;
            clamped  = 1'b1;
        end else if (word_in > F_MAX) begin
            word_out = F_MAX;
            clamped  = 1'b1;
        end
    end

endmodule

// File: rtl/swipt_lock_ctrl.sv
// SWIPT PLL sequencer: loads the default frequency, acquires and tracks lock,
// forwards the clamped PLL frequency word and freezes on heartbeat loss.
//
// state   | meaning
// IDLE    | waiting for the first heartbeat
// LOAD    | one-cycle load_freq strobe with F_DEFAULT
// ACQUIRE | coarse gain, counting error-free samples toward lock
// TRACK   | fine gain, locked, counting error samples toward unlock
// HOLD    | heartbeat lost: frequency and counters frozen
module swipt_lock_ctrl
    import swipt_pkg::*;
#(
    parameter logic [31:0] F_DEFAULT   = F_DEFAULT_VAL,
    parameter logic [31:0] F_MIN       = 32'h8000,
    parameter logic [31:0] F_MAX       = 32'hC000,
    parameter logic [4:0]  LG_ACQ      = LG_ACQ_VAL,
    parameter logic [4:0]  LG_TRACK    = LG_TRACK_VAL,
    parameter int unsigned LOCK_CNT    = 1024,
    parameter int unsigned UNLOCK_CNT  = 64,
    parameter int unsigned ACQ_TIMEOUT = 1_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        swipt_alive,
    input  logic [1:0]  pll_error,
    input  logic [31:0] pll_phase,
    output logic        load_freq,
    output logic [4:0]  lgcoefficient,
    output logic [31:0] freq_out,
    output logic        locked,
    output logic [2:0]  ctrl_state
);

    state_t      state;
    logic [31:0] phase_q;
    logic [1:0]  err_q;
    logic [15:0] lock_cnt;
    logic [15:0] unlock_cnt;
    logic [23:0] timeout_cnt;
    logic [3:0]  retry_cnt;

    logic [31:0] phase_clamped;
    logic        clamped;
    logic        sample_good;
    logic [15:0] lock_inc;
    logic [15:0] unlock_inc;
    logic [23:0] timeout_inc;
    logic [3:0]  retry_inc;
    logic        lock_hit;
    logic        unlock_hit;
    logic        timeout_hit;
    logic        retry_hit;

    freq_clamp #(
        .F_MIN (F_MIN),
        .F_MAX (F_MAX)
    ) u_clamp (
        .word_in  (phase_q),
        .word_out (phase_clamped),
        .clamped  (clamped)
    );

    // Detector result and phase word are registered together so the clamp flag
    // and pll_error always describe the same sample.
    always_comb begin
        sample_good = (err_q == ERR_ALIGNED) && !clamped;
        lock_inc    = (lock_cnt    == 16'hFFFF)    ? lock_cnt    : lock_cnt    + 16'd1;
        unlock_inc  = (unlock_cnt  == 16'hFFFF)    ? unlock_cnt  : unlock_cnt  + 16'd1;
        timeout_inc = (timeout_cnt == 24'hFFFFFF)  ? timeout_cnt : timeout_cnt + 24'd1;
        retry_inc   = (retry_cnt   == 4'hF)        ? retry_cnt   : retry_cnt   + 4'd1;
        lock_hit    = sample_good  && (32'(lock_inc)    >= LOCK_CNT);
        unlock_hit  = !sample_good && (32'(unlock_inc)  >= UNLOCK_CNT);
        timeout_hit = 32'(timeout_inc) >= ACQ_TIMEOUT;
        retry_hit   = 32'(retry_inc)   >= MAX_RETRY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            phase_q       <= '0;
            err_q         <= '0;
            freq_out      <= F_DEFAULT;
            load_freq     <= 1'b0;
            lgcoefficient <= LG_ACQ;
            locked        <= 1'b0;
            lock_cnt      <= '0;
            unlock_cnt    <= '0;
            timeout_cnt   <= '0;
            retry_cnt     <= '0;
        end else begin
            phase_q       <= pll_phase;
            err_q         <= pll_error;
            load_freq     <= 1'b0;
            lgcoefficient <= LG_ACQ;
            locked        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (swipt_alive) begin
                        state       <= S_LOAD;
                        load_freq   <= 1'b1;
                        freq_out    <= F_DEFAULT;
                        lock_cnt    <= '0;
                        unlock_cnt  <= '0;
                        timeout_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    state <= swipt_alive ? S_ACQUIRE : S_HOLD;
                end
                S_ACQUIRE: begin
                    if (!swipt_alive) begin
                        state <= S_HOLD;
                    end else begin
                        freq_out <= phase_clamped;
                        if (lock_hit) begin
                            state         <= S_TRACK;
                            lgcoefficient <= LG_TRACK;
                            locked        <= 1'b1;
                            retry_cnt     <= '0;
                            lock_cnt      <= '0;
                            unlock_cnt    <= '0;
                            timeout_cnt   <= '0;
                        end else if (timeout_hit) begin
                            lock_cnt    <= '0;
                            unlock_cnt  <= '0;
                            timeout_cnt <= '0;
                            if (retry_hit) begin
                                state     <= S_LOAD;
                                load_freq <= 1'b1;
                                freq_out  <= F_DEFAULT;
                                retry_cnt <= '0;
                            end else begin
                                retry_cnt <= retry_inc;
                            end
                        end else begin
                            lock_cnt    <= sample_good ? lock_inc : '0;
                            timeout_cnt <= timeout_inc;
                        end
                    end
                end
                S_TRACK: begin
                    if (!swipt_alive) begin
                        state <= S_HOLD;
                    end else begin
                        freq_out <= phase_clamped;
                        if (unlock_hit) begin
                            state       <= S_ACQUIRE;
                            lock_cnt    <= '0;
                            unlock_cnt  <= '0;
                            timeout_cnt <= '0;
                        end else begin
                            unlock_cnt    <= sample_good ? '0 : unlock_inc;
                            lgcoefficient <= LG_TRACK;
                            locked        <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (swipt_alive) begin
                        state       <= S_ACQUIRE;
                        lock_cnt    <= '0;
                        unlock_cnt  <= '0;
                        timeout_cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_swipt_lock_ctrl.sv
// Bench for swipt_lock_ctrl: vector table for reset/lock, directed corner
// sequences, then randomized traffic against a behavioural model.
module tb_swipt_lock_ctrl;

    localparam logic [31:0] FDEF  = 32'h9C40;
    localparam logic [31:0] FMIN  = 32'h8000;
    localparam logic [31:0] FMAX  = 32'hC000;
    localparam int          N_LOCK   = 8;
    localparam int          N_UNLOCK = 4;
    localparam int          N_TMO    = 32;
    localparam int          N_RETRY  = 2;

    localparam int M_IDLE = 0, M_LOAD = 1, M_ACQ = 2, M_TRACK = 3, M_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        swipt_alive;
    logic [1:0]  pll_error;
    logic [31:0] pll_phase;
    logic        load_freq;
    logic [4:0]  lgcoefficient;
    logic [31:0] freq_out;
    logic        locked;
    logic [2:0]  ctrl_state;

    always #5 clk = ~clk;

    swipt_lock_ctrl #(
        .F_DEFAULT   (FDEF),
        .F_MIN       (FMIN),
        .F_MAX       (FMAX),
        .LG_ACQ      (5'd12),
        .LG_TRACK    (5'd16),
        .LOCK_CNT    (N_LOCK),
        .UNLOCK_CNT  (N_UNLOCK),
        .ACQ_TIMEOUT (N_TMO),
        .MAX_RETRY   (N_RETRY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .swipt_alive   (swipt_alive),
        .pll_error     (pll_error),
        .pll_phase     (pll_phase),
        .load_freq     (load_freq),
        .lgcoefficient (lgcoefficient),
        .freq_out      (freq_out),
        .locked        (locked),
        .ctrl_state    (ctrl_state)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Behavioural model: one phase/error sample is consumed per edge, one
    // edge after it was presented.
    int          m_mode, m_lock, m_unlock, m_time, m_retry;
    logic [31:0] m_freq;
    logic        m_load, m_locked;
    logic [4:0]  m_lg;
    logic [1:0]  s_err;
    logic [31:0] s_phase;

    task automatic model_clear();
        m_lock = 0; m_unlock = 0; m_time = 0;
    endtask

    task automatic model_step();
        logic [1:0]  cur_err;
        logic [31:0] cur_phase, cl;
        bit          good;
        if (rst) begin
            m_mode = M_IDLE; m_freq = FDEF; m_retry = 0; model_clear();
            s_err = 0; s_phase = 0;
            m_load = 0; m_lg = 5'd12; m_locked = 0;
            return;
        end
        cur_err = s_err; cur_phase = s_phase;
        s_err = pll_error; s_phase = pll_phase;
        cl = (cur_phase < FMIN) ? FMIN : (cur_phase > FMAX) ? FMAX : cur_phase;
        good = (cur_err == 2'b00) && (cl == cur_phase);
        m_load = 0;
        if (m_mode == M_IDLE) begin
            if (swipt_alive) begin
                m_mode = M_LOAD; m_freq = FDEF; m_load = 1; model_clear();
            end
        end else if (!swipt_alive) begin
            m_mode = M_HOLD;
        end else begin
            case (m_mode)
                M_LOAD: m_mode = M_ACQ;
                M_ACQ: begin
                    m_freq = cl;
                    m_lock = good ? m_lock + 1 : 0;
                    m_time = m_time + 1;
                    if (m_lock >= N_LOCK) begin
                        m_mode = M_TRACK; m_retry = 0; model_clear();
                    end else if (m_time >= N_TMO) begin
                        model_clear();
                        m_retry = m_retry + 1;
                        if (m_retry >= N_RETRY) begin
                            m_mode = M_LOAD; m_freq = FDEF; m_load = 1; m_retry = 0;
                        end
                    end
                end
                M_TRACK: begin
                    m_freq = cl;
                    m_unlock = good ? 0 : m_unlock + 1;
                    if (m_unlock >= N_UNLOCK) begin
                        m_mode = M_ACQ; model_clear();
                    end
                end
                default: begin
                    m_mode = M_ACQ; model_clear();
                end
            endcase
        end
        m_locked = (m_mode == M_TRACK);
        m_lg     = m_locked ? 5'd16 : 5'd12;
    endtask

    task automatic drive(input logic r, input logic a, input logic [1:0] e, input logic [31:0] p);
        rst = r; swipt_alive = a; pll_error = e; pll_phase = p;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        r;
        logic        a;
        logic [1:0]  e;
        logic [31:0] p;
        logic [2:0]  st;
        logic        ld;
        logic [4:0]  lg;
        logic        lk;
        logic [31:0] f;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hold_left;
        bit good_mode;
        int k;
        logic        r_r, r_a;
        logic [1:0]  r_e;
        logic [31:0] r_p;

        // Reset release, LOAD strobe, then eight aligned samples to lock.
        vecs[0]  = '{1'b1, 1'b1, 2'b00, 32'h9D00, 3'd0, 1'b0, 5'd12, 1'b0, FDEF};
        vecs[1]  = '{1'b0, 1'b1, 2'b00, 32'h9D00, 3'd1, 1'b1, 5'd12, 1'b0, FDEF};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 32'h9D00, 3'd2, 1'b0, 5'd12, 1'b0, FDEF};
        for (int i = 3; i <= 9; i++)
            vecs[i] = '{1'b0, 1'b1, 2'b00, 32'h9D00, 3'd2, 1'b0, 5'd12, 1'b0, 32'h9D00};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 32'h9D00, 3'd3, 1'b0, 5'd16, 1'b1, 32'h9D00};

        drive(1'b1, 1'b1, 2'b00, 32'h9D00);
        tick();
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].r, vecs[i].a, vecs[i].e, vecs[i].p);
            tick();
            chk($sformatf("vec%0d_state", i),  64'(ctrl_state),    64'(vecs[i].st));
            chk($sformatf("vec%0d_load", i),   64'(load_freq),     64'(vecs[i].ld));
            chk($sformatf("vec%0d_lg", i),     64'(lgcoefficient), 64'(vecs[i].lg));
            chk($sformatf("vec%0d_locked", i), 64'(locked),        64'(vecs[i].lk));
            chk($sformatf("vec%0d_freq", i),   64'(freq_out),      64'(vecs[i].f));
        end

        // Unlock: three errors, one aligned sample restarts the count.
        drive(1'b0, 1'b1, 2'b10, 32'h9D00);
        repeat (3) tick();
        drive(1'b0, 1'b1, 2'b00, 32'h9D00);
        tick();
        chk("unlock_restart_state", 64'(ctrl_state), 64'd3);
        drive(1'b0, 1'b1, 2'b10, 32'h9D00);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (ctrl_state != 3'd3) break;
        end
        chk("unlock_ticks", 64'(n), 64'd5);
        chk("unlock_state", 64'(ctrl_state), 64'd2);
        chk("unlock_locked", 64'(locked), 64'd0);
        chk("unlock_lg", 64'(lgcoefficient), 64'd12);
        chk("unlock_freq", 64'(freq_out), 64'h9D00);

        // Retry exhaustion: two 32-cycle timeouts, then LOAD.
        drive(1'b0, 1'b1, 2'b01, 32'h9D00);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick(); n++;
            if (ctrl_state == 3'd1) break;
        end
        chk("retry_ticks", 64'(n), 64'd64);
        chk("retry_load", 64'(load_freq), 64'd1);
        chk("retry_freq", 64'(freq_out), 64'(FDEF));

        // Clamp: out-of-range word is limited and never counts toward lock.
        drive(1'b0, 1'b1, 2'b00, 32'hFFFF0000);
        tick();
        chk("load_single_pulse", 64'(load_freq), 64'd0);
        chk("load_then_acq", 64'(ctrl_state), 64'd2);
        repeat (19) tick();
        chk("clamp_freq", 64'(freq_out), 64'hC000);
        chk("clamp_no_lock", 64'(ctrl_state), 64'd2);
        drive(1'b0, 1'b1, 2'b00, 32'h9D00);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); n++;
            if (ctrl_state == 3'd3) break;
        end
        chk("clamp_lock_ticks", 64'(n), 64'd9);
        chk("relock_freq", 64'(freq_out), 64'h9D00);
        chk("relock_lg", 64'(lgcoefficient), 64'd16);

        // Heartbeat loss in TRACK, recovery, then reset mid-ACQUIRE.
        drive(1'b0, 1'b0, 2'b00, 32'h9D00);
        tick();
        chk("hold_state", 64'(ctrl_state), 64'd4);
        chk("hold_locked", 64'(locked), 64'd0);
        chk("hold_lg", 64'(lgcoefficient), 64'd12);
        drive(1'b0, 1'b0, 2'b00, 32'hA000);
        repeat (3) tick();
        chk("hold_frozen_freq", 64'(freq_out), 64'h9D00);
        chk("hold_stays", 64'(ctrl_state), 64'd4);
        drive(1'b0, 1'b1, 2'b00, 32'hA000);
        tick();
        chk("hold_exit_state", 64'(ctrl_state), 64'd2);
        chk("hold_exit_freq", 64'(freq_out), 64'h9D00);
        tick();
        chk("acq_follow_freq", 64'(freq_out), 64'hA000);
        drive(1'b1, 1'b1, 2'b00, 32'hA000);
        tick();
        chk("rst_state", 64'(ctrl_state), 64'd0);
        chk("rst_freq", 64'(freq_out), 64'(FDEF));
        chk("rst_load", 64'(load_freq), 64'd0);
        chk("rst_lg", 64'(lgcoefficient), 64'd12);
        chk("rst_locked", 64'(locked), 64'd0);
        tick();
        chk("rst_overrides_alive", 64'(ctrl_state), 64'd0);
        drive(1'b0, 1'b1, 2'b00, 32'hA000);
        tick();
        chk("rst_release_load", 64'(ctrl_state), 64'd1);

        // Randomized traffic against the model.
        drive(1'b1, 1'b1, 2'b00, 32'h9D00);
        tick();
        hold_left = 0;
        good_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            r_r = ($urandom_range(999) == 0);
            if (hold_left > 0) begin
                r_a = 1'b0; hold_left--;
            end else if ($urandom_range(99) < 2) begin
                r_a = 1'b0; hold_left = $urandom_range(5);
            end else begin
                r_a = 1'b1;
            end
            if ($urandom_range(63) == 0) good_mode = !good_mode;
            if (good_mode) r_e = ($urandom_range(49) == 0) ? 2'($urandom_range(3)) : 2'b00;
            else           r_e = 2'($urandom_range(3));
            k = $urandom_range(19);
            if (k == 0) begin
                r_p = $urandom;
            end else if (k == 1) begin
                case ($urandom_range(3))
                    0:       r_p = FMIN;
                    1:       r_p = FMAX;
                    2:       r_p = FMIN - 32'd1;
                    default: r_p = FMAX + 32'd1;
                endcase
            end else begin
                r_p = 32'h9000 + 32'($urandom_range(4095));
            end
            drive(r_r, r_a, r_e, r_p);
            tick();
            chk($sformatf("random_cycle%0d", c),
                {22'd0, ctrl_state, load_freq, lgcoefficient, locked, freq_out},
                {22'd0, 3'(m_mode), m_load, m_lg, m_locked, m_freq});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
